isp_pio_arb: RTL



---
 rtl/isp_pio_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/isp_pio_arb.sv
// Round-robin arbiter and CSF/RDF/WRF sequencer for the shared ISP1362 PIO bus.
// state | meaning: IDLE wait | SETUP cs+addr | STROBE rd/wr low | HOLD done | RECOV cs high
module isp_pio_arb #(
  parameter int STROBE_CYC     = 4,
  parameter int CMD_RECOV_CYC  = 11,
  parameter int DATA_RECOV_CYC = 4
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic [1:0]  I_REQ,
  input  logic [1:0]  I_CMD,
  input  logic [1:0]  I_WR,
  input  logic [15:0] I_WDATA0,
  input  logic [15:0] I_WDATA1,
  output logic [1:0]  O_GNT,
  output logic [1:0]  O_DONE,
  output logic [15:0] O_RDATA,
  output logic        O_BUSY,
  output logic [1:0]  O_DC_ADDR,
  output logic        O_DC_CSF,
  output logic        O_DC_RDF,
  output logic        O_DC_WRF,
  output logic [15:0] O_DC_DATA,
  output logic        O_DC_DATA_OE,
  input  logic [15:0] I_DC_DATA
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV} state_t;

  localparam logic [4:0] STB_LOAD  = 5'(STROBE_CYC - 1);
  localparam logic [4:0] CMD_LOAD  = 5'(CMD_RECOV_CYC - 1);
  localparam logic [4:0] DATA_LOAD = 5'(DATA_RECOV_CYC - 1);

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        last_q, id_q, cmd_q, wr_q;
  logic [15:0] wdata_q;
  logic        any_req, win, start;
  logic        sel_id, sel_cmd, sel_wr, win_nxt;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_oh;

  assign any_req = |I_REQ;
  // on a tie the requester that was not granted last wins
  assign win     = (I_REQ == 2'b11) ? ~last_q : I_REQ[1];
  assign start   = (state == IDLE) && any_req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:   if (any_req) state_nxt = SETUP;
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = STB_LOAD;
      end
      STROBE: if (cnt == 5'd0) state_nxt = HOLD;
              else cnt_nxt = cnt - 5'd1;
      HOLD: begin
        if (cmd_q && (CMD_RECOV_CYC > 0)) begin
          state_nxt = RECOV;
          cnt_nxt   = CMD_LOAD;
        end else if (!cmd_q && (DATA_RECOV_CYC > 0)) begin
          state_nxt = RECOV;
          cnt_nxt   = DATA_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      RECOV:  if (cnt == 5'd0) state_nxt = IDLE;
              else cnt_nxt = cnt - 5'd1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // last_q reset to 0 so requester 1 wins the first tie
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      last_q  <= 1'b0;
      id_q    <= 1'b0;
      cmd_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 16'h0000;
    end else if (start) begin
      last_q  <= win;
      id_q    <= win;
      cmd_q   <= I_CMD[win];
      wr_q    <= I_WR[win];
      wdata_q <= win ? I_WDATA1 : I_WDATA0;
    end
  end

  always_comb begin
    sel_id    = id_q;
    sel_cmd   = cmd_q;
    sel_wr    = wr_q;
    sel_wdata = wdata_q;
    if (state == IDLE) begin
      sel_id    = win;
      sel_cmd   = I_CMD[win];
      sel_wr    = I_WR[win];
      sel_wdata = win ? I_WDATA1 : I_WDATA0;
    end
  end

  assign sel_oh  = sel_id ? 2'b10 : 2'b01;
  assign win_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);

  // outputs decoded from the next state so every pin comes straight from a flop
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      O_DC_CSF     <= 1'b1;
      O_DC_RDF     <= 1'b1;
      O_DC_WRF     <= 1'b1;
      O_DC_DATA_OE <= 1'b0;
      O_GNT        <= 2'b00;
      O_DONE       <= 2'b00;
      O_BUSY       <= 1'b0;
      O_DC_ADDR    <= 2'b00;
      O_DC_DATA    <= 16'h0000;
      O_RDATA      <= 16'h0000;
    end else begin
      O_DC_CSF     <= ~win_nxt;
      O_DC_RDF     <= ~((state_nxt == STROBE) && !sel_wr);
      O_DC_WRF     <= ~((state_nxt == STROBE) && sel_wr);
      O_DC_DATA_OE <= win_nxt && sel_wr;
      O_GNT        <= win_nxt ? sel_oh : 2'b00;
      O_DONE       <= (state_nxt == HOLD) ? sel_oh : 2'b00;
      O_BUSY       <= (state_nxt != IDLE);
      if (start) begin
        O_DC_ADDR <= {sel_id, sel_cmd};
        if (sel_wr) O_DC_DATA <= sel_wdata;
      end
      if ((state == STROBE) && (cnt == 5'd0) && !wr_q) O_RDATA <= I_DC_DATA;
    end
  end

endmodule
